// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD output register.
// Command words, status layout and FSM states.
package lcd_pkg;

  typedef enum logic [2:0] {
    PWRUP,
    IDLE,
    SETUP,
    EN_HI,
    HOLD,
    EXEC
  } lcd_state_e;

  localparam int ST_BUSY    = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_PWRUP   = 3;
  localparam int ST_LVL_LSB = 4;

  localparam int CW_ON     = 31;
  localparam int CW_CLROVF = 30;
  localparam int CW_RS     = 9;

  localparam int CMD_W = 9;

  function automatic logic is_long_cmd(
    input logic       rs,
    input logic [7:0] data
  );
    return !rs && (data[7:2] == 6'd0);
  endfunction

  function automatic int at_least_1(input int v);
    return (v <= 0) ? 1 : v;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Command queue between the LSU write port and the LCD sequencer.
// A push into a full queue is taken only when a pop frees a slot.
module lcd_cmd_fifo
  import lcd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             push,
  input  logic             pop,
  input  logic [CMD_W-1:0] wdata,
  output logic [CMD_W-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  localparam int AW = $clog2(DEPTH);

  logic [CMD_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign rdata   = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge i_clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + LW'(1);
      end else if (do_pop && !do_push) begin
        count <= count - LW'(1);
      end
    end
  end

endmodule

// File: rtl/lcd_ctrl.sv
// LSU-mapped HD44780 driver: queues command words and replays
// them with setup, enable, hold and execution timing.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int T_PWRUP_CYC = 750000,
  parameter int T_SETUP_CYC = 3,
  parameter int T_EN_CYC    = 12,
  parameter int T_HOLD_CYC  = 3,
  parameter int T_EXEC_CYC  = 2000,
  parameter int T_LONG_CYC  = 82000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wr_en,
  input  logic [31:0] i_wr_data,
  output logic [31:0] o_status,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic        o_lcd_on
);

  localparam int N_PWR = at_least_1(T_PWRUP_CYC);
  localparam int N_SU  = at_least_1(T_SETUP_CYC);
  localparam int N_EN  = at_least_1(T_EN_CYC);
  localparam int N_HO  = at_least_1(T_HOLD_CYC);
  localparam int N_EX  = at_least_1(T_EXEC_CYC);
  localparam int N_LG  = at_least_1(T_LONG_CYC);
  localparam int T_MAX =
    max2(max2(max2(N_PWR, N_SU), max2(N_EN, N_HO)), max2(N_EX, N_LG));
  localparam int CW = $clog2(T_MAX + 1);
  localparam int LW = $clog2(FIFO_DEPTH + 1);

  // Counter holds N-1 on entry so each state lasts exactly N cycles.
  localparam logic [CW-1:0] LD_PWR = CW'(N_PWR - 1);
  localparam logic [CW-1:0] LD_SU  = CW'(N_SU - 1);
  localparam logic [CW-1:0] LD_EN  = CW'(N_EN - 1);
  localparam logic [CW-1:0] LD_HO  = CW'(N_HO - 1);
  localparam logic [CW-1:0] LD_EX  = CW'(N_EX - 1);
  localparam logic [CW-1:0] LD_LG  = CW'(N_LG - 1);

  lcd_state_e       state_q;
  lcd_state_e       state_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic             cnt_done;
  logic             pop;
  logic             rs_q;
  logic [7:0]       data_q;
  logic             on_q;
  logic             ovf_q;
  logic             wr_clr;
  logic             wr_cmd;
  logic             drop;
  logic [CMD_W-1:0] head;
  logic             full;
  logic             empty;
  logic [LW-1:0]    level;
  logic [31:0]      status;
  logic             unused_wr_bits;

  assign unused_wr_bits = ^{i_wr_data[29:10], i_wr_data[8]};

  assign wr_clr = i_wr_en && i_wr_data[CW_CLROVF];
  assign wr_cmd = i_wr_en && !i_wr_data[CW_CLROVF];
  assign drop   = wr_cmd && full && !pop;

  lcd_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .LW    (LW)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .push    (wr_cmd),
    .pop     (pop),
    .wdata   ({i_wr_data[CW_RS], i_wr_data[7:0]}),
    .rdata   (head),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  assign cnt_done = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_done ? cnt_q : cnt_q - CW'(1);
    pop     = 1'b0;
    unique case (state_q)
      PWRUP: begin
        if (cnt_done) state_d = IDLE;
      end
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = SETUP;
          cnt_d   = LD_SU;
        end
      end
      SETUP: begin
        if (cnt_done) begin
          state_d = EN_HI;
          cnt_d   = LD_EN;
        end
      end
      EN_HI: begin
        if (cnt_done) begin
          state_d = HOLD;
          cnt_d   = LD_HO;
        end
      end
      HOLD: begin
        if (cnt_done) begin
          state_d = EXEC;
          cnt_d   = is_long_cmd(rs_q, data_q) ? LD_LG : LD_EX;
        end
      end
      EXEC: begin
        if (cnt_done) state_d = IDLE;
      end
      default: begin
        state_d = PWRUP;
        cnt_d   = LD_PWR;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= PWRUP;
      cnt_q   <= LD_PWR;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      on_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (pop) begin
        {rs_q, data_q} <= head;
      end
      if (i_wr_en) begin
        on_q <= i_wr_data[CW_ON];
      end
      if (wr_clr) begin
        ovf_q <= 1'b0;
      end else if (drop) begin
        ovf_q <= 1'b1;
      end
    end
  end

  always_comb begin
    status                   = '0;
    status[ST_BUSY]          = (state_q != IDLE) || !empty;
    status[ST_FULL]          = full;
    status[ST_OVF]           = ovf_q;
    status[ST_PWRUP]         = (state_q == PWRUP);
    status[ST_LVL_LSB +: 4]  = 4'(level);
  end

  // Reads back as zero while reset is held.
  assign o_status   = i_reset ? status : '0;
  assign o_lcd_data = data_q;
  assign o_lcd_rs   = rs_q;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_en   = (state_q == EN_HI);
  assign o_lcd_on   = on_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Bench for lcd_ctrl: directed scenarios plus random traffic
// against a timestamp-based model of the command sequencer.
module tb_lcd_ctrl;

  localparam int PW = 20;
  localparam int SU = 2;
  localparam int EN = 4;
  localparam int HO = 2;
  localparam int EX = 10;
  localparam int LG = 40;
  localparam int DP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr  = 1'b0;
  logic [31:0] wd  = '0;
  logic [31:0] o_status;
  logic [7:0]  o_lcd_data;
  logic        o_lcd_rs;
  logic        o_lcd_rw;
  logic        o_lcd_en;
  logic        o_lcd_on;

  always #5 clk = ~clk;

  lcd_ctrl #(
    .FIFO_DEPTH  (DP),
    .T_PWRUP_CYC (PW),
    .T_SETUP_CYC (SU),
    .T_EN_CYC    (EN),
    .T_HOLD_CYC  (HO),
    .T_EXEC_CYC  (EX),
    .T_LONG_CYC  (LG)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_wr_en    (wr),
    .i_wr_data  (wd),
    .o_status   (o_status),
    .o_lcd_data (o_lcd_data),
    .o_lcd_rs   (o_lcd_rs),
    .o_lcd_rw   (o_lcd_rw),
    .o_lcd_en   (o_lcd_en),
    .o_lcd_on   (o_lcd_on)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Model: each command's phases are absolute edge numbers.
  logic [8:0] q[$];
  logic [8:0] acc[$];
  logic [8:0] seen[$];
  bit         m_ovf;
  bit         m_on;
  logic [8:0] m_cur;
  int         e;
  int         idle_at;
  int         en_lo;
  int         en_hi;
  bit         en_prev;
  int         en_run;

  task automatic m_reset();
    q.delete();
    acc.delete();
    m_ovf   = 0;
    m_on    = 0;
    m_cur   = '0;
    e       = 0;
    idle_at = PW;
    en_lo   = -10;
    en_hi   = -11;
    en_prev = 0;
    en_run  = 0;
  endtask

  function automatic bit m_long(input logic [8:0] c);
    return !c[8] && (c[7:2] == 6'd0);
  endfunction

  task automatic m_edge(input bit w, input logic [31:0] d);
    bit pop;
    e++;
    pop = (e - 1 >= idle_at) && (q.size() > 0);
    if (pop) begin
      m_cur   = q.pop_front();
      en_lo   = e + SU;
      en_hi   = e + SU + EN - 1;
      idle_at = e + SU + EN + HO + (m_long(m_cur) ? LG : EX);
    end
    if (w) begin
      m_on = d[31];
      if (d[30]) m_ovf = 0;
      else if (q.size() >= DP) m_ovf = 1;
      else begin
        q.push_back({d[9], d[7:0]});
        acc.push_back({d[9], d[7:0]});
      end
    end
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s    = '0;
    s[0] = (e < idle_at) || (q.size() != 0);
    s[1] = (q.size() == DP);
    s[2] = m_ovf;
    s[3] = (e < PW);
    s[7:4] = 4'(q.size());
    return s;
  endfunction

  task automatic compare();
    check("status", o_status, m_status());
    check("en", {31'b0, o_lcd_en}, {31'b0, (e >= en_lo && e <= en_hi)});
    check("rs_data", {23'b0, o_lcd_rs, o_lcd_data}, {23'b0, m_cur});
    check("on", {31'b0, o_lcd_on}, {31'b0, m_on});
    check("rw", {31'b0, o_lcd_rw}, 32'd0);
    if (o_lcd_en && !en_prev) begin
      seen.push_back({o_lcd_rs, o_lcd_data});
      check("order", {23'b0, o_lcd_rs, o_lcd_data},
            acc.size() > 0 ? {23'b0, acc.pop_front()} : 32'hDEAD);
    end
    if (o_lcd_en) en_run++;
    else if (en_run > 0) begin
      check("en_width", en_run, EN);
      en_run = 0;
    end
    en_prev = o_lcd_en;
  endtask

  task automatic tick(input bit w, input logic [31:0] d);
    wr = w;
    wd = d;
    @(posedge clk);
    m_edge(w, d);
    #1;
    compare();
  endtask

  task automatic drain(input int max);
    int k = 0;
    while (!(e >= idle_at && q.size() == 0) && k < max) begin
      tick(0, '0);
      k++;
    end
    tick(0, '0);
    check("drain_busy", {31'b0, o_status[0]}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1);
  end

  initial begin
    int k;
    int first_en;
    logic [31:0] d;

    m_reset();
    #12;
    check("rst_status", o_status, 32'd0);
    check("rst_out", {22'b0, o_lcd_rs, o_lcd_data, o_lcd_en, o_lcd_on},
          32'd0);
    @(negedge clk);
    rst = 1'b1;

    // 1: write during power-up
    tick(1, 32'h8000_0241);
    check("t1_on", {31'b0, o_lcd_on}, 32'd1);
    check("t1_pwrup", {31'b0, o_status[3]}, 32'd1);
    first_en = -1;
    for (int i = 0; i < 60; i++) begin
      tick(0, '0);
      if (o_lcd_en && first_en < 0) first_en = e;
    end
    check("t1_first_en", first_en, PW + 1 + SU);
    check("t1_data", {23'b0, seen[0]}, 32'h141);
    drain(200);

    // 2: clear command
    tick(0, '0);
    tick(1, 32'h0000_0001);
    k = 0;
    while (o_status[0] === 1'b1 && k < 200) begin
      k++;
      tick(0, '0);
    end
    check("t2_busy_cycles", k, 1 + SU + EN + HO + LG);

    // 3: overflow with six writes while busy
    seen.delete();
    tick(1, 32'h0000_0001);
    tick(0, '0);
    tick(0, '0);
    for (int i = 0; i < 6; i++) tick(1, 32'h2A0 + i);
    check("t3_ovf", {31'b0, o_status[2]}, 32'd1);
    check("t3_full", {31'b0, o_status[1]}, 32'd1);

    // 4: clear overflow
    tick(1, 32'h4000_0000);
    check("t4_ovf", {31'b0, o_status[2]}, 32'd0);
    check("t4_level", {28'b0, o_status[7:4]}, 32'd4);
    check("t4_on", {31'b0, o_lcd_on}, 32'd0);
    drain(500);
    check("t3_n_issued", seen.size(), 5);
    if (seen.size() == 5)
      for (int i = 0; i < 4; i++)
        check("t3_order", {23'b0, seen[i + 1]}, 32'h1A0 + i);

    // 6: push into a full queue on the cycle IDLE pops
    tick(1, 32'h0000_0001);
    for (int i = 0; i < 4; i++) tick(1, 32'h2B0 + i);
    k = 0;
    while (!(e >= idle_at && q.size() == DP) && k < 200) begin
      tick(0, '0);
      k++;
    end
    tick(1, 32'h2B7);
    check("t6_level", {28'b0, o_status[7:4]}, 32'd4);
    check("t6_ovf", {31'b0, o_status[2]}, 32'd0);
    drain(800);

    // 5: reset in the second enable cycle
    tick(1, 32'h8000_0255);
    k = 0;
    while (o_lcd_en !== 1'b1 && k < 100) begin
      tick(0, '0);
      k++;
    end
    tick(0, '0);
    check("t5_en_before", {31'b0, o_lcd_en}, 32'd1);
    wr  = 1'b0;
    rst = 1'b0;
    #1;
    check("t5_en_now", {31'b0, o_lcd_en}, 32'd0);
    check("t5_status", o_status, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    m_reset();
    tick(0, '0);
    check("t5_pwrup", {31'b0, o_status[3]}, 32'd1);
    for (int i = 0; i < PW + 5; i++) tick(0, '0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      d = $urandom;
      d[30] = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0) d[7:2] = 6'd0;
      tick($urandom_range(0, 99) < 30, d);
    end
    drain(1000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
